alu_seq_engine: RTL and testbench

- Sequential, handshaked ALU engine. It accepts one operation request (ctrl, x, y) from an initiator, such as a bench sequencer or a future datapath controller.
- It computes the result with the team's 13-op ALU encoding. Single-cycle ops complete in one busy cycle. Variable shifts (0111, 1000) run bit-serially, one position per cycle.
- It returns out/carry/err on a valid/ready response channel. It is the responder end of the op-request interface that our ALU benches drive.

---
 rtl/alu_seq_engine.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_engine.sv
// Handshaked sequential ALU engine: accepts one (ctrl, x, y) request, computes it with the
// 13-op ALU encoding (variable shifts run bit-serially) and returns out/carry/err on a valid/ready channel.
module alu_seq_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_ctrl,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_carry,
    output logic             resp_err
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       ctrl_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_nxt_s;
    logic [SHW-1:0]   count_r;
    logic [SHW-1:0]   count_nxt_s;
    logic [WIDTH-1:0] shifted_s;
    logic             is_shift_s;
    logic             accept_s;
    logic             load_resp_s;
    logic [WIDTH+1:0] resp_nxt_s;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic [WIDTH-1:0] resp_out_r;
    logic             resp_carry_r;
    logic             resp_err_r;

    // Single-cycle ALU result packed as {err, carry, out}; variable shifts are handled serially elsewhere.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       c,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH+1:0] res;
        sum = {(WIDTH+1){1'b0}};
        res = {(WIDTH+2){1'b0}};
        case (c)
            4'b0000: begin
                sum = {1'b0, a} + {1'b0, b};
                res = {1'b0, sum};
            end
            4'b0001: begin
                sum = {1'b0, a} - {1'b0, b};
                res = {1'b0, sum};
            end
            4'b0010: res = {2'b00, a & b};
            4'b0011: res = {2'b00, a | b};
            4'b0100: res = {2'b00, ~a};
            4'b0101: res = {2'b00, a ^ b};
            4'b0110: res = {2'b00, ~(a | b)};
            4'b0111: res = {2'b00, b};
            4'b1000: res = {2'b00, b};
            4'b1001: res = {2'b00, a[WIDTH-1], a[WIDTH-1:1]};
            4'b1010: res = {2'b00, a[WIDTH-2:0], a[WIDTH-1]};
            4'b1011: res = {2'b00, a[0], a[WIDTH-1:1]};
            4'b1100: res = {2'b00, {(WIDTH-1){1'b0}}, (a == b)};
            default: res = {1'b1, 1'b0, {WIDTH{1'b0}}};
        endcase
        return res;
    endfunction

    assign is_shift_s = (ctrl_r == 4'b0111) || (ctrl_r == 4'b1000);
    assign accept_s   = req_valid && req_ready_r;
    assign shifted_s  = (ctrl_r == 4'b0111) ? {work_r[WIDTH-2:0], 1'b0}
                                            : {1'b0, work_r[WIDTH-1:1]};

    // Next-state, serial shifter and response-load decisions.
    always_comb begin
        state_nxt_s = state_r;
        work_nxt_s  = work_r;
        count_nxt_s = count_r;
        load_resp_s = 1'b0;
        resp_nxt_s  = {resp_err_r, resp_carry_r, resp_out_r};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (is_shift_s) begin
                    work_nxt_s  = y_r;
                    count_nxt_s = x_r[SHW-1:0];
                    if (x_r[SHW-1:0] == {SHW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                        load_resp_s = 1'b1;
                        resp_nxt_s  = {2'b00, y_r};
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                    load_resp_s = 1'b1;
                    resp_nxt_s  = alu_eval(ctrl_r, x_r, y_r);
                end
            end
            ST_SHIFT: begin
                work_nxt_s  = shifted_s;
                count_nxt_s = count_r - SHW'(1);
                if (count_r == SHW'(1)) begin
                    state_nxt_s = ST_DONE;
                    load_resp_s = 1'b1;
                    resp_nxt_s  = {2'b00, shifted_s};
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, operand latches and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ctrl_r       <= 4'b0000;
            x_r          <= {WIDTH{1'b0}};
            y_r          <= {WIDTH{1'b0}};
            work_r       <= {WIDTH{1'b0}};
            count_r      <= {SHW{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_out_r   <= {WIDTH{1'b0}};
            resp_carry_r <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            work_r       <= work_nxt_s;
            count_r      <= count_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                ctrl_r <= req_ctrl;
                x_r    <= req_x;
                y_r    <= req_y;
            end else begin
                ctrl_r <= ctrl_r;
                x_r    <= x_r;
                y_r    <= y_r;
            end
            if (load_resp_s) begin
                resp_err_r   <= resp_nxt_s[WIDTH+1];
                resp_carry_r <= resp_nxt_s[WIDTH];
                resp_out_r   <= resp_nxt_s[WIDTH-1:0];
            end else begin
                resp_err_r   <= resp_err_r;
                resp_carry_r <= resp_carry_r;
                resp_out_r   <= resp_out_r;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_out   = resp_out_r;
    assign resp_carry = resp_carry_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_alu_seq_engine.sv
// Bench for alu_seq_engine: directed plan steps plus random ops against an arithmetic reference model.
module tb_alu_seq_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_ctrl;
    logic [7:0] req_x;
    logic [7:0] req_y;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_out;
    logic       resp_carry;
    logic       resp_err;

    int vectors = 0;
    int miscompares = 0;

    alu_seq_engine #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_x(req_x), .req_y(req_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_out(resp_out), .resp_carry(resp_carry), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {err, carry, out[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] ref_op(input int c, input int x, input int y);
        int o;
        int cy;
        int e;
        o = 0; cy = 0; e = 0;
        case (c)
            0:  begin o = (x + y) % 256; cy = (x + y > 255) ? 1 : 0; end
            1:  begin o = (x - y + 256) % 256; cy = (x < y) ? 1 : 0; end
            2:  o = x & y;
            3:  o = x | y;
            4:  o = 255 - x;
            5:  o = x ^ y;
            6:  o = 255 - (x | y);
            7:  o = (y * (1 << (x % 8))) % 256;
            8:  o = y / (1 << (x % 8));
            9:  o = (x / 2) + ((x >= 128) ? 128 : 0);
            10: o = ((x * 2) % 256) + (x / 128);
            11: o = (x / 2) + ((x % 2) * 128);
            12: o = (x == y) ? 1 : 0;
            default: e = 1;
        endcase
        return {e[0], cy[0], o[7:0]};
    endfunction

    function automatic int ref_lat(input int c, input int x);
        return (c == 7 || c == 8) ? 2 + (x % 8) : 2;
    endfunction

    // Issue one op (at a negedge), check latency, result, back-pressure hold and return to idle.
    task automatic run_op(input int c, input int x, input int y, input int bp);
        logic [9:0] exp;
        int n;
        int edges;
        exp = ref_op(c, x, y);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", req_ready, 1);
        req_valid  = 1'b1;
        req_ctrl   = c[3:0];
        req_x      = x[7:0];
        req_y      = y[7:0];
        resp_ready = (bp == 0);
        @(negedge clk);
        req_valid = 1'b0;
        edges = 1;
        while (!resp_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check($sformatf("latency op%0d", c), edges, ref_lat(c, x));
        check($sformatf("out op%0d", c), resp_out, exp[7:0]);
        check($sformatf("carry op%0d", c), resp_carry, exp[8]);
        check($sformatf("err op%0d", c), resp_err, exp[9]);
        check("ready_low_in_done", req_ready, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid_hold", resp_valid, 1);
            check("bp_out_hold", {resp_err, resp_carry, resp_out}, exp);
            check("bp_ready_low", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("valid_after_xfer", resp_valid, 0);
        check("idle_after_xfer", req_ready, 1);
    endtask

    initial begin
        int saw_valid;
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_ctrl   = 4'b0000;
        req_x      = 8'h11;
        req_y      = 8'h22;
        resp_ready = 1'b1;

        // Reset held two edges with a request pending.
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_outputs", {resp_err, resp_carry, resp_out}, 0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_nothing_accepted", resp_valid, 0);
        check("post_rst_idle", req_ready, 1);

        // Opcode sweep with x=01, y=FF.
        for (int c = 0; c <= 12; c++) run_op(c, 8'h01, 8'hFF, 0);

        // Serial shifts.
        run_op(7, 8'h07, 8'h03, 0);
        run_op(8, 8'h00, 8'hA5, 0);

        // Back-pressure on an overflowing add.
        run_op(0, 8'h80, 8'h80, 5);

        // Illegal op then legal op.
        run_op(14, 8'h12, 8'h34, 0);
        run_op(2, 8'h12, 8'h34, 0);

        // Response transfer and new request in the same DONE cycle.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_ctrl   = 4'b0101;
        req_x      = 8'h3C;
        req_y      = 8'h0F;
        @(negedge clk);
        req_ctrl = 4'b0000;
        req_x    = 8'h05;
        req_y    = 8'h07;
        @(negedge clk);
        check("simul_done_valid", resp_valid, 1);
        check("simul_first_out", resp_out, 8'h33);
        resp_ready = 1'b1;
        @(negedge clk);
        check("simul_xfer_not_accepted", req_ready, 1);
        check("simul_xfer_valid_low", resp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("simul_accept_from_idle", req_ready, 0);
        @(negedge clk);
        check("simul_second_valid", resp_valid, 1);
        check("simul_second_out", resp_out, 8'h0C);
        @(negedge clk);
        check("simul_second_idle", req_ready, 1);

        // Reset during the 4th SHIFT edge.
        req_valid = 1'b1;
        req_ctrl  = 4'b0111;
        req_x     = 8'h07;
        req_y     = 8'h03;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midshift_rst_idle", req_ready, 1);
        check("midshift_rst_valid", resp_valid, 0);
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) saw_valid++;
        end
        check("midshift_no_response", saw_valid, 0);
        run_op(7, 8'h02, 8'h21, 0);

        // Random ops with random back-pressure.
        for (int k = 0; k < 40; k++) begin
            run_op($urandom_range(15, 0), $urandom_range(255, 0), $urandom_range(255, 0),
                   $urandom_range(3, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
